// File: rtl/mmio_responder_if.sv
// CPU data-port bus seen by the MMIO responder.
// Master drives addr/wdata/we/re; slave returns registered rdata.
interface mmio_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output rdata
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder: UART TX holding reg, UART RX FIFO, cycle/instret counters.
// Ports: clk, rst (sync high), bus (slave), inst_retire, uart_tx_*, uart_rx_*.
module mmio_responder #(
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mmio_responder_if.slave   bus,
  input  logic              inst_retire,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    TX_EMPTY,
    TX_FULL
  } tx_state_t;

  logic [7:0] off;
  logic       sel;
  logic       any_we;
  logic       ld_stat;
  logic       ld_rx;
  logic       ld_cyc;
  logic       ld_ins;
  logic       st_tx;
  logic       st_clr;

  assign off     = bus.addr[7:0];
  assign sel     = bus.addr[31:28] == 4'h8;
  assign any_we  = |bus.we;
  assign ld_stat = bus.re && sel && off == 8'h00;
  assign ld_rx   = bus.re && sel && off == 8'h04;
  assign ld_cyc  = bus.re && sel && off == 8'h10;
  assign ld_ins  = bus.re && sel && off == 8'h14;
  assign st_tx   = any_we && sel && off == 8'h08;
  assign st_clr  = any_we && sel && off == 8'h18;

  logic unused_bits;
  assign unused_bits = ^{bus.wdata[31:8], bus.addr[27:8]};

  // TX holding register
  tx_state_t tx_state;
  tx_state_t tx_next;
  logic      tx_cap;

  always_comb begin
    tx_next = tx_state;
    tx_cap  = 1'b0;
    unique case (tx_state)
      TX_EMPTY: begin
        if (st_tx) begin
          tx_next = TX_FULL;
          tx_cap  = 1'b1;
        end
      end
      TX_FULL: begin
        // store while full is dropped even if it drains now
        if (uart_tx_ready) tx_next = TX_EMPTY;
      end
      default: tx_next = TX_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_EMPTY;
      uart_tx_data <= 8'h00;
    end else begin
      tx_state <= tx_next;
      if (tx_cap) uart_tx_data <= bus.wdata[7:0];
    end
  end

  assign uart_tx_valid = tx_state == TX_FULL;

  // RX FIFO
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [AW-1:0] rx_wp;
  logic [AW-1:0] rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_nonempty;
  logic          rx_enq;
  logic          rx_deq;

  assign rx_nonempty   = rx_cnt != '0;
  assign uart_rx_ready = rx_cnt != CW'(RX_DEPTH);
  assign rx_enq        = uart_rx_valid && uart_rx_ready;
  assign rx_deq        = ld_rx && rx_nonempty;

  always_ff @(posedge clk) begin
    if (rx_enq) rx_mem[rx_wp] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_enq) rx_wp <= rx_wp + 1'b1;
      if (rx_deq) rx_rp <= rx_rp + 1'b1;
      unique case ({rx_enq, rx_deq})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Counters
  logic [31:0] cyc_cnt;
  logic [31:0] ins_cnt;

  always_ff @(posedge clk) begin
    if (rst || st_clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) ins_cnt <= ins_cnt + 32'd1;
    end
  end

  // Load data, sampled from pre-update state
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      ld_stat: rdata_d = {30'b0, rx_nonempty, !uart_tx_valid};
      ld_rx:   rdata_d = rx_nonempty ? {24'b0, rx_mem[rx_rp]} : '0;
      ld_cyc:  rdata_d = cyc_cnt;
      ld_ins:  rdata_d = ins_cnt;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) bus.rdata <= '0;
    else     bus.rdata <= rdata_d;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the CPU data-memory port. It services loads and stores from the execute stage whose address falls in the I/O region, and returns load data registered into the mem/wb stage, matching synchronous-RAM timing. It owns the UART transmit holding register, a small UART receive FIFO, and the cycle and retired-instruction counters.

## Interface
- `RX_DEPTH`, 4: receive FIFO entries; power of 2, at least 2.
- `clk` in 1: core clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: byte address from the ALU, execute stage.
- `wdata` in 32: store data; only `wdata[7:0]` is used.
- `we` in 4: store byte mask; any nonzero value is a store. Already gated by the core for killed instructions.
- `re` in 1: load request, gated by the core like `we`.
- `inst_retire` in 1: one pulse per retired non-bubble instruction.
- `rdata` out 32: load data, registered.
- `uart_tx_data` out 8: byte to transmitter.
- `uart_tx_valid` out 1: byte offered; held until accepted.
- `uart_tx_ready` in 1: transmitter accepts byte.
- `uart_rx_data` in 8: byte from receiver.
- `uart_rx_valid` in 1: receiver offers byte.
- `uart_rx_ready` out 1: FIFO can accept byte.

## Operation
- Select: `addr[31:28] == 4'h8`. Decode uses `addr[7:0]`. Unselected or unmapped accesses have no effect, and loads from them return 0.
- Address map:
  - 0x80000000 R: `{30'b0, rx_nonempty, tx_empty}`.
  - 0x80000004 R: `{24'b0, rx head byte}`; dequeues the head.
  - 0x80000008 W: TX byte.
  - 0x80000010 R: cycle counter.
  - 0x80000014 R: instruction counter.
  - 0x80000018 W: clear both counters; data is ignored.
- Loads and stores in the same cycle are handled independently.
- TX holding register, single entry:
  - States: EMPTY (`uart_tx_valid` = 0) and FULL (`uart_tx_valid` = 1).
  - EMPTY + store to 0x80000008: capture `wdata[7:0]`, go FULL.
  - FULL + `uart_tx_ready`: go EMPTY.
  - A store while FULL is dropped, even if the handshake completes in that same cycle.
  - `uart_tx_data` is stable while FULL.
- RX FIFO:
  - Occupancy counter is `$clog2(RX_DEPTH)+1` bits. Read and write pointers wrap modulo `RX_DEPTH`.
  - `uart_rx_ready` = not full (combinational from registered count).
  - Enqueue on `uart_rx_valid && uart_rx_ready`.
  - Dequeue on a load of 0x80000004 when non-empty.
  - A load of 0x80000004 when empty returns 0 and pointers are unchanged.
  - Simultaneous enqueue and dequeue leave the count unchanged. A byte enqueued this cycle is not visible to a load in the same cycle.
- Counters, 32-bit, wrap at 2^32:
  - Cycle counter increments every non-reset cycle.
  - Instruction counter increments when `inst_retire` = 1.
  - A store to 0x80000018 sets both to 0 on the next edge; clear beats increment.
- Reset clears:
  - `rdata` = 0.
  - `uart_tx_valid` = 0; `uart_tx_data` = 0, dropping any pending byte.
  - FIFO emptied; `uart_rx_ready` = 1 from the first cycle after reset.
  - Both counters = 0.

## Timing
- Load latency is 1 cycle: `rdata` at edge N+1 reflects state sampled during cycle N, before that cycle's updates.
  - Counter reads return the pre-increment value.
  - Status read returns pre-handshake flags.
- `rdata` = 0 in any cycle after which no selected, mapped load occurred.
- Store effects are visible to a load issued in the next cycle.
- A captured TX byte asserts `uart_tx_valid` at edge N+1 after the store in cycle N.
- Throughput:
  - TX: one byte per 2 cycles (capture, then handshake).
  - RX: one byte per cycle while not full.

## Test plan
- Reset, then load 0x80000000 -> `rdata` = 0x00000001; `uart_rx_ready` = 1; `uart_tx_valid` = 0.
- TX handshake:
  - Store 0x41 to 0x80000008 with `uart_tx_ready` = 0 -> `uart_tx_valid` = 1, `uart_tx_data` = 0x41, status = 0x0.
  - Then store 0x42 -> dropped.
  - Raise `uart_tx_ready` for 1 cycle -> valid drops; status = 0x1.
- RX FIFO fill and drain:
  - Push 0x11, 0x22, 0x33, 0x44 -> `uart_rx_ready` = 0 after 4th; status = 0x3.
  - Four loads of 0x80000004 -> 0x11, 0x22, 0x33, 0x44 in order.
  - Fifth load -> 0; status = 0x1.
- Simultaneous RX ops: FIFO holds 1 byte; enqueue and dequeue in the same cycle -> count stays 1 and the old head is returned.
- Counters:
  - Run 10 cycles from reset with 4 `inst_retire` pulses -> load 0x80000010 returns the cycle count at the issue cycle; load 0x80000014 = 4.
  - Store to 0x80000018 concurrent with `inst_retire` -> next-cycle loads return 0 and 0.
- Mid-operation reset: pending TX byte plus 2 RX bytes, assert `rst` -> all outputs at reset values; subsequent loads of 0x80000004 return 0.
